param_register_file: RTL and testbench

//  Parametrised general-purpose register file for the 8-bit datapath, replacing the fixed 4x8 bank.
//  - One synchronous write port, two combinational read ports, one buffer register.
//  - Hardware context save/restore to a shadow bank, one register per cycle, with busy/done handshake.
//  - Sits between the control unit (write selects, context requests) and the ALU operand muxes.

---
 rtl/param_register_file.sv | 145 ++++++++++++++
 tb/tb_param_register_file.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// param_register_file: parametrised general-purpose register file for the 8-bit datapath.
// One synchronous write port, two combinational read ports, a buffer register and a
// hardware context save/restore engine that copies one register per cycle to/from a
// shadow bank.
//
// Optional feature macro: REGFILE_WR_BYPASS_EN
//   defined   -> write-through: read ports show Wr_data when writing the selected
//                register (and not busy); Buff_out shows Buff_in while Buff_wr=1.
//   undefined -> reads return stored values only.
//
// Ports:
//   Reg_clk, Reg_rst_n            clock, async active-low reset
//   Wr_en, Wr_sel, Wr_data        general register write (dropped while Ctx_busy)
//   Rd_sel_a/b, Rd_data_a/b       combinational read ports
//   Buff_wr, Buff_in, Buff_out    buffer register (independent of context engine)
//   Ctx_save, Ctx_restore         context transfer requests (sampled in IDLE only)
//   Ctx_busy, Ctx_done            transfer in progress / one-cycle completion pulse
//   Regs_flat                     all registers, reg i at [i*DATA_W +: DATA_W]
module param_register_file #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 4,
  localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
  input  logic                         Reg_clk,
  input  logic                         Reg_rst_n,
  input  logic                         Wr_en,
  input  logic [SEL_W-1:0]             Wr_sel,
  input  logic [DATA_W-1:0]            Wr_data,
  input  logic [SEL_W-1:0]             Rd_sel_a,
  output logic [DATA_W-1:0]            Rd_data_a,
  input  logic [SEL_W-1:0]             Rd_sel_b,
  output logic [DATA_W-1:0]            Rd_data_b,
  input  logic                         Buff_wr,
  input  logic [DATA_W-1:0]            Buff_in,
  output logic [DATA_W-1:0]            Buff_out,
  input  logic                         Ctx_save,
  input  logic                         Ctx_restore,
  output logic                         Ctx_busy,
  output logic                         Ctx_done,
  output logic [NUM_REGS*DATA_W-1:0]   Regs_flat
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic                done_q, done_d;
  logic                last_idx;
  logic                wr_ok;

  logic [DATA_W-1:0]   regs_q   [NUM_REGS];
  logic [DATA_W-1:0]   shadow_q [NUM_REGS];
  logic [DATA_W-1:0]   buff_q;

  assign last_idx = (idx_q == SEL_W'(NUM_REGS - 1));
  assign Ctx_busy = (state_q != ST_IDLE);
  assign Ctx_done = done_q;
  assign wr_ok    = Wr_en && (state_q == ST_IDLE);

  // FSM state, transfer index and done pulse registers
  always_ff @(posedge Reg_clk or negedge Reg_rst_n) begin
    if (!Reg_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; save wins over restore when both are requested
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (Ctx_save)         state_d = ST_SAVE;
        else if (Ctx_restore) state_d = ST_RESTORE;
      end
      ST_SAVE, ST_RESTORE: begin
        if (last_idx) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // General registers: restore copy has the port while busy, external writes only in IDLE
  always_ff @(posedge Reg_clk or negedge Reg_rst_n) begin
    if (!Reg_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (state_q == ST_RESTORE) begin
      regs_q[idx_q] <= shadow_q[idx_q];
    end else if (wr_ok) begin
      regs_q[Wr_sel] <= Wr_data;
    end
  end

  // Shadow bank, filled one register per cycle during SAVE
  always_ff @(posedge Reg_clk or negedge Reg_rst_n) begin
    if (!Reg_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else if (state_q == ST_SAVE) begin
      shadow_q[idx_q] <= regs_q[idx_q];
    end
  end

  // Buffer register, unaffected by context transfers
  always_ff @(posedge Reg_clk or negedge Reg_rst_n) begin
    if (!Reg_rst_n)   buff_q <= '0;
    else if (Buff_wr) buff_q <= Buff_in;
  end

  // Read ports and buffer output
`ifdef REGFILE_WR_BYPASS_EN
  assign Rd_data_a = (wr_ok && (Wr_sel == Rd_sel_a)) ? Wr_data : regs_q[Rd_sel_a];
  assign Rd_data_b = (wr_ok && (Wr_sel == Rd_sel_b)) ? Wr_data : regs_q[Rd_sel_b];
  assign Buff_out  = Buff_wr ? Buff_in : buff_q;
`else
  assign Rd_data_a = regs_q[Rd_sel_a];
  assign Rd_data_b = regs_q[Rd_sel_b];
  assign Buff_out  = buff_q;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign Regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned FLAT_W   = NUM_REGS * DATA_W;

  logic                Reg_clk = 1'b0;
  logic                Reg_rst_n;
  logic                Wr_en;
  logic [SEL_W-1:0]    Wr_sel;
  logic [DATA_W-1:0]   Wr_data;
  logic [SEL_W-1:0]    Rd_sel_a;
  logic [DATA_W-1:0]   Rd_data_a;
  logic [SEL_W-1:0]    Rd_sel_b;
  logic [DATA_W-1:0]   Rd_data_b;
  logic                Buff_wr;
  logic [DATA_W-1:0]   Buff_in;
  logic [DATA_W-1:0]   Buff_out;
  logic                Ctx_save;
  logic                Ctx_restore;
  logic                Ctx_busy;
  logic                Ctx_done;
  logic [FLAT_W-1:0]   Regs_flat;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: architectural register, shadow and buffer contents
  logic [DATA_W-1:0] m_regs   [NUM_REGS];
  logic [DATA_W-1:0] m_shadow [NUM_REGS];
  logic [DATA_W-1:0] m_buff;

  param_register_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .Reg_clk(Reg_clk), .Reg_rst_n(Reg_rst_n),
    .Wr_en(Wr_en), .Wr_sel(Wr_sel), .Wr_data(Wr_data),
    .Rd_sel_a(Rd_sel_a), .Rd_data_a(Rd_data_a),
    .Rd_sel_b(Rd_sel_b), .Rd_data_b(Rd_data_b),
    .Buff_wr(Buff_wr), .Buff_in(Buff_in), .Buff_out(Buff_out),
    .Ctx_save(Ctx_save), .Ctx_restore(Ctx_restore),
    .Ctx_busy(Ctx_busy), .Ctx_done(Ctx_done),
    .Regs_flat(Regs_flat)
  );

  always #5 Reg_clk = ~Reg_clk;

  function automatic logic [FLAT_W-1:0] model_flat();
    logic [FLAT_W-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = m_regs[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge Reg_clk);
    #1;
  endtask

  task automatic idle_inputs();
    Wr_en = 1'b0; Wr_sel = '0; Wr_data = '0;
    Rd_sel_a = '0; Rd_sel_b = '0;
    Buff_wr = 1'b0; Buff_in = '0;
    Ctx_save = 1'b0; Ctx_restore = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_regs[i] = '0;
      m_shadow[i] = '0;
    end
    m_buff = '0;
  endtask

  // Single write while idle; model updates after the edge
  task automatic do_write(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] data);
    Wr_en = 1'b1; Wr_sel = sel; Wr_data = data;
    tick();
    Wr_en = 1'b0;
    m_regs[sel] = data;
  endtask

  // Issue a transfer, optionally pound the ports with ignored traffic while busy,
  // then check busy length, done pulse and that nothing restarts.
  task automatic run_transfer(input bit is_save, input bit junk, input string tag);
    int busy_cycles;
    Ctx_save = is_save; Ctx_restore = !is_save;
    tick();
    Ctx_save = 1'b0; Ctx_restore = 1'b0;
    if (is_save) for (int i = 0; i < NUM_REGS; i++) m_shadow[i] = m_regs[i];
    else         for (int i = 0; i < NUM_REGS; i++) m_regs[i] = m_shadow[i];
    busy_cycles = 0;
    while (Ctx_busy && busy_cycles < 50) begin
      if (junk) begin
        Wr_en = 1'b1; Wr_sel = SEL_W'($urandom); Wr_data = DATA_W'($urandom);
        Ctx_save = 1'b1; Ctx_restore = 1'b1;
        Buff_wr = 1'b1; Buff_in = DATA_W'($urandom);
        m_buff = Buff_in;
      end
      tick();
      busy_cycles++;
    end
    idle_inputs();
    n_cmp++;
    if (busy_cycles !== NUM_REGS) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cycles, NUM_REGS);
    end
    n_cmp++;
    if (Ctx_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_pulse: got %b expected 1", tag, Ctx_done);
    end
    tick();
    n_cmp++;
    if (Ctx_done !== 1'b0 || Ctx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", tag, Ctx_done, Ctx_busy);
    end
    n_cmp++;
    if (Regs_flat !== model_flat()) begin
      n_fail++;
      $display("FAIL %s regs_flat: got %h expected %h", tag, Regs_flat, model_flat());
    end
    n_cmp++;
    if (Buff_out !== m_buff) begin
      n_fail++;
      $display("FAIL %s buff_out: got %h expected %h", tag, Buff_out, m_buff);
    end
  endtask

  task automatic test_reset();
    do_write(2'd1, 8'hA5);
    Buff_wr = 1'b1; Buff_in = 8'h3C;
    tick();
    Buff_wr = 1'b0;
    Rd_sel_a = 2'd1; Rd_sel_b = 2'd1;
    #1;
    n_cmp++;
    if (Rd_data_a !== 8'hA5) begin
      n_fail++;
      $display("FAIL reset_prewrite: got %h expected a5", Rd_data_a);
    end
    #1 Reg_rst_n = 1'b0;
    #1;
    model_clear();
    n_cmp++;
    if (Rd_data_a !== '0 || Rd_data_b !== '0 || Buff_out !== '0) begin
      n_fail++;
      $display("FAIL reset_reads: got a=%h b=%h buff=%h expected 0", Rd_data_a, Rd_data_b, Buff_out);
    end
    n_cmp++;
    if (Regs_flat !== '0 || Ctx_busy !== 1'b0 || Ctx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got flat=%h busy=%b done=%b expected 0", Regs_flat, Ctx_busy, Ctx_done);
    end
    @(negedge Reg_clk);
    Reg_rst_n = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    do_write(2'd0, 8'h11);
    do_write(2'd1, 8'h22);
    do_write(2'd2, 8'h33);
    do_write(2'd3, 8'h44);
    Rd_sel_a = 2'd2; Rd_sel_b = 2'd3;
    #1;
    n_cmp++;
    if (Rd_data_a !== 8'h33 || Rd_data_b !== 8'h44) begin
      n_fail++;
      $display("FAIL write_read_ports: got a=%h b=%h expected 33/44", Rd_data_a, Rd_data_b);
    end
    n_cmp++;
    if (Regs_flat !== 32'h44332211) begin
      n_fail++;
      $display("FAIL write_read_flat: got %h expected 44332211", Regs_flat);
    end
  endtask

  task automatic test_save_restore();
    run_transfer(1'b1, 1'b0, "save");
    for (int i = 0; i < NUM_REGS; i++) do_write(SEL_W'(i), 8'hFF);
    n_cmp++;
    if (Regs_flat !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL overwrite_ff: got %h expected ffffffff", Regs_flat);
    end
    run_transfer(1'b0, 1'b0, "restore");
    n_cmp++;
    if (Regs_flat !== 32'h44332211) begin
      n_fail++;
      $display("FAIL restore_image: got %h expected 44332211", Regs_flat);
    end
  endtask

  // Writes, buffer loads and requests all hit the block during SAVE
  task automatic test_busy_protection();
    run_transfer(1'b1, 1'b1, "busy_protect");
    n_cmp++;
    if (Regs_flat[7:0] !== 8'h11) begin
      n_fail++;
      $display("FAIL busy_reg0: got %h expected 11", Regs_flat[7:0]);
    end
  endtask

  task automatic test_priority_overlap();
    Ctx_save = 1'b1; Ctx_restore = 1'b1;
    Wr_en = 1'b1; Wr_sel = 2'd2; Wr_data = 8'h77;
    tick();
    idle_inputs();
    m_regs[2] = 8'h77;
    for (int i = 0; i < NUM_REGS; i++) m_shadow[i] = m_regs[i];
    for (int n = 0; n < 50 && Ctx_busy; n++) tick();
    n_cmp++;
    if (Regs_flat !== model_flat()) begin
      n_fail++;
      $display("FAIL priority_regs: got %h expected %h", Regs_flat, model_flat());
    end
    tick();
    do_write(2'd2, 8'h00);
    run_transfer(1'b0, 1'b0, "priority_restore");
    n_cmp++;
    if (Regs_flat[23:16] !== 8'h77) begin
      n_fail++;
      $display("FAIL priority_shadow2: got %h expected 77", Regs_flat[23:16]);
    end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp_a, exp_b, exp_buf;
    Wr_en = 1'b1; Wr_sel = 2'd1; Wr_data = 8'h5A;
    Rd_sel_a = 2'd1; Rd_sel_b = 2'd0;
    Buff_wr = 1'b1; Buff_in = 8'hC3;
`ifdef REGFILE_WR_BYPASS_EN
    exp_a = 8'h5A; exp_buf = 8'hC3;
`else
    exp_a = m_regs[1]; exp_buf = m_buff;
`endif
    exp_b = m_regs[0];
    #1;
    n_cmp++;
    if (Rd_data_a !== exp_a || Rd_data_b !== exp_b) begin
      n_fail++;
      $display("FAIL bypass_read: got a=%h b=%h expected %h/%h", Rd_data_a, Rd_data_b, exp_a, exp_b);
    end
    n_cmp++;
    if (Buff_out !== exp_buf) begin
      n_fail++;
      $display("FAIL bypass_buff: got %h expected %h", Buff_out, exp_buf);
    end
    tick();
    idle_inputs();
    m_regs[1] = 8'h5A; m_buff = 8'hC3;
    Rd_sel_a = 2'd1;
    #1;
    n_cmp++;
    if (Rd_data_a !== 8'h5A || Buff_out !== 8'hC3) begin
      n_fail++;
      $display("FAIL bypass_after: got a=%h buff=%h expected 5a/c3", Rd_data_a, Buff_out);
    end
  endtask

  // Request held through done restarts immediately; a write in the done cycle lands
  task automatic test_back_to_back();
    int n;
    Ctx_save = 1'b1;
    tick();
    for (int i = 0; i < NUM_REGS; i++) m_shadow[i] = m_regs[i];
    n = 0;
    while (!Ctx_done && n < 50) begin tick(); n++; end
    Wr_en = 1'b1; Wr_sel = 2'd3; Wr_data = 8'hB7;
    tick();
    Wr_en = 1'b0; Ctx_save = 1'b0;
    m_regs[3] = 8'hB7;
    n_cmp++;
    if (Ctx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_restart: got busy=%b expected 1", Ctx_busy);
    end
    for (int i = 0; i < NUM_REGS; i++) m_shadow[i] = m_regs[i];
    n = 0;
    while (Ctx_busy && n < 50) begin tick(); n++; end
    tick();
    n_cmp++;
    if (Regs_flat[31:24] !== 8'hB7) begin
      n_fail++;
      $display("FAIL b2b_done_write: got %h expected b7", Regs_flat[31:24]);
    end
    do_write(2'd3, 8'h00);
    run_transfer(1'b0, 1'b0, "b2b_restore");
  endtask

  task automatic test_reset_mid_transfer();
    Ctx_save = 1'b1;
    tick();
    Ctx_save = 1'b0;
    tick();
    tick();
    Reg_rst_n = 1'b0;
    #1;
    model_clear();
    n_cmp++;
    if (Ctx_busy !== 1'b0 || Regs_flat !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b flat=%h expected 0", Ctx_busy, Regs_flat);
    end
    @(negedge Reg_clk);
    Reg_rst_n = 1'b1;
    tick();
    for (int i = 0; i < NUM_REGS; i++) do_write(SEL_W'(i), 8'h99);
    run_transfer(1'b0, 1'b0, "reset_mid_restore");
  endtask

  task automatic test_random();
    int op;
    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0, 1, 2: do_write(SEL_W'($urandom), DATA_W'($urandom));
        3: begin
          Buff_wr = 1'b1; Buff_in = DATA_W'($urandom);
          tick();
          Buff_wr = 1'b0;
          m_buff = Buff_in;
        end
        4: run_transfer(1'b1, 1'($urandom), "rand_save");
        default: run_transfer(1'b0, 1'($urandom), "rand_restore");
      endcase
      Rd_sel_a = SEL_W'($urandom); Rd_sel_b = SEL_W'($urandom);
      #1;
      n_cmp++;
      if (Rd_data_a !== m_regs[Rd_sel_a] || Rd_data_b !== m_regs[Rd_sel_b]) begin
        n_fail++;
        $display("FAIL rand_read it=%0d: got a=%h b=%h expected %h/%h", it,
                 Rd_data_a, Rd_data_b, m_regs[Rd_sel_a], m_regs[Rd_sel_b]);
      end
      n_cmp++;
      if (Regs_flat !== model_flat() || Buff_out !== m_buff) begin
        n_fail++;
        $display("FAIL rand_state it=%0d: got flat=%h buff=%h expected %h/%h", it,
                 Regs_flat, Buff_out, model_flat(), m_buff);
      end
    end
  endtask

  initial begin
    Reg_rst_n = 1'b0;
    idle_inputs();
    model_clear();
    #12 Reg_rst_n = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_save_restore();
    test_busy_protection();
    test_priority_overlap();
    test_bypass();
    test_back_to_back();
    test_reset_mid_transfer();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
